// File: rtl/f_d_reg_pkg.sv
// Shared constants, D-stage payload type and fetch-address helper for the F/D pipeline register.
package f_d_reg_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned EXC_W   = 5;

    localparam logic [EXC_W-1:0]   EXC_NONE   = 5'd0;
    localparam logic [EXC_W-1:0]   EXC_ADEL   = 5'd4;
    localparam logic [PC_W-1:0]    PC_RESET   = 32'h0000_3000;
    localparam logic [PC_W-1:0]    PC_HANDLER = 32'h0000_4180;
    localparam logic [PC_W-1:0]    IM_LO      = 32'h0000_3000;
    localparam logic [PC_W-1:0]    IM_HI      = 32'h0000_6FFC;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [EXC_W-1:0]   excCode;
        logic               bd;
        logic               valid;
    } dStage_t;

    // Fetch address is illegal when misaligned or outside the instruction memory window (IM_HI inclusive).
    function automatic logic isFetchAdel(input logic [PC_W-1:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/f_exc_check.sv
// Fetch address check: flags AdEL and replaces the fetched word with a nop when the address is illegal.
module f_exc_check
    import f_d_reg_pkg::*;
(
    input  logic [PC_W-1:0]    fPc,
    input  logic [INSTR_W-1:0] fInstr,
    output logic [EXC_W-1:0]   excCode_c,
    output logic [INSTR_W-1:0] instrMasked_c
);

    logic adel;

    always_comb begin
        adel          = isFetchAdel(fPc);
        excCode_c     = EXC_NONE;
        instrMasked_c = fInstr;
        if (adel) begin
            excCode_c     = EXC_ADEL;
            instrMasked_c = NOP_INSTR;
        end
    end

endmodule

// File: rtl/f_d_reg.sv
// F/D pipeline register: one-cycle stage boundary with reset > Req > Stall > Clr > load priority.
module f_d_reg
    import f_d_reg_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                Req,
    input  logic                Stall,
    input  logic                Clr,
    input  logic [PC_W-1:0]     F_PC,
    input  logic [INSTR_W-1:0]  F_Instr,
    input  logic                F_BD,
    output logic [PC_W-1:0]     D_PC,
    output logic [INSTR_W-1:0]  D_Instr,
    output logic [EXC_W-1:0]    Raw_D_ExcCode,
    output logic                D_BD,
    output logic                D_Valid
);

    localparam dStage_t RESET_STATE = '{pc: PC_RESET, instr: NOP_INSTR, excCode: EXC_NONE,
                                        bd: 1'b0, valid: 1'b0};

    logic [EXC_W-1:0]   fExcCode;
    logic [INSTR_W-1:0] fInstrMasked;
    dStage_t            dReg;
    dStage_t            loadVal;
    dStage_t            reqVal;
    dStage_t            clrVal;

    f_exc_check uExcCheck (
        .fPc           (F_PC),
        .fInstr        (F_Instr),
        .excCode_c     (fExcCode),
        .instrMasked_c (fInstrMasked)
    );

    // Candidate payloads for each update kind; the clocked process only selects among them.
    always_comb begin
        loadVal = '{pc: F_PC, instr: fInstrMasked, excCode: fExcCode, bd: F_BD, valid: 1'b1};
        reqVal  = '{pc: PC_HANDLER, instr: NOP_INSTR, excCode: EXC_NONE, bd: 1'b0, valid: 1'b0};
        clrVal  = '{pc: F_PC, instr: NOP_INSTR, excCode: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dReg <= RESET_STATE;
        end else if (Req) begin
            dReg <= reqVal;
        end else if (Stall) begin
            dReg <= dReg;
        end else if (Clr) begin
            dReg <= clrVal;
        end else begin
            dReg <= loadVal;
        end
    end

    assign D_PC          = dReg.pc;
    assign D_Instr       = dReg.instr;
    assign Raw_D_ExcCode = dReg.excCode;
    assign D_BD          = dReg.bd;
    assign D_Valid       = dReg.valid;

endmodule

// File: tb/tb_f_d_reg.sv
// Self-checking bench for f_d_reg: behavioural model, per-cycle compare, directed and random stimulus.
module tb_f_d_reg;

    logic        clk = 1'b0;
    logic        reset, Req, Stall, Clr, F_BD;
    logic [31:0] F_PC, F_Instr;
    logic [31:0] D_PC, D_Instr;
    logic [4:0]  Raw_D_ExcCode;
    logic        D_BD, D_Valid;

    int checks = 0;
    int errors = 0;

    // Model state: what the D outputs must be after the most recent edge.
    logic        mKnown = 1'b0;
    logic [31:0] mPc, mInstr;
    logic [4:0]  mCode;
    logic        mBd, mValid;

    f_d_reg dut (
        .clk           (clk),
        .reset         (reset),
        .Req           (Req),
        .Stall         (Stall),
        .Clr           (Clr),
        .F_PC          (F_PC),
        .F_Instr       (F_Instr),
        .F_BD          (F_BD),
        .D_PC          (D_PC),
        .D_Instr       (D_Instr),
        .Raw_D_ExcCode (Raw_D_ExcCode),
        .D_BD          (D_BD),
        .D_Valid       (D_Valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the stage rules, evaluated on each rising edge.
    always @(posedge clk) begin
        logic bad;
        if (reset === 1'b1) begin
            mPc = 32'h3000; mInstr = 0; mCode = 0; mBd = 0; mValid = 0; mKnown = 1'b1;
        end else if (Req) begin
            mPc = 32'h4180; mInstr = 0; mCode = 0; mBd = 0; mValid = 0;
        end else if (Stall) begin
            // everything held
        end else if (Clr) begin
            mPc = F_PC; mInstr = 0; mCode = 0; mBd = 0; mValid = 0;
        end else begin
            bad    = (F_PC % 4 != 0) || (F_PC < 32'h3000) || (F_PC > 32'h6FFC);
            mPc    = F_PC;
            mInstr = bad ? 32'h0 : F_Instr;
            mCode  = bad ? 5'd4 : 5'd0;
            mBd    = F_BD;
            mValid = 1'b1;
        end
    end

    // Single compare process, mid-cycle, once the model has seen a reset.
    always @(negedge clk) begin
        if (mKnown) begin
            chk("D_PC", D_PC, mPc);
            chk("D_Instr", D_Instr, mInstr);
            chk("Raw_D_ExcCode", 32'(Raw_D_ExcCode), 32'(mCode));
            chk("D_BD", 32'(D_BD), 32'(mBd));
            chk("D_Valid", 32'(D_Valid), 32'(mValid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setIn(input logic r, input logic q, input logic s, input logic c,
                         input logic [31:0] pc, input logic [31:0] ins, input logic bd);
        reset = r; Req = q; Stall = s; Clr = c; F_PC = pc; F_Instr = ins; F_BD = bd;
    endtask

    initial begin
        setIn(1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick(); tick();
        chk("lit_reset_pc", D_PC, 32'h3000);
        chk("lit_reset_valid", 32'(D_Valid), 32'd0);
        chk("lit_reset_code", 32'(Raw_D_ExcCode), 32'd0);

        setIn(0, 0, 0, 0, 32'h3000, 32'h3C010001, 0); tick();
        chk("lit_load_pc", D_PC, 32'h3000);
        chk("lit_load_instr", D_Instr, 32'h3C010001);
        chk("lit_load_valid", 32'(D_Valid), 32'd1);

        setIn(0, 0, 0, 0, 32'h3002, 32'h12345678, 0); tick();
        chk("lit_unaligned_instr", D_Instr, 32'h0);
        chk("lit_unaligned_code", 32'(Raw_D_ExcCode), 32'd4);
        chk("lit_unaligned_pc", D_PC, 32'h3002);
        chk("lit_unaligned_valid", 32'(D_Valid), 32'd1);
        setIn(0, 0, 0, 0, 32'h7000, 32'h12345678, 0); tick();
        chk("lit_7000_code", 32'(Raw_D_ExcCode), 32'd4);
        setIn(0, 0, 0, 0, 32'h6FFC, 32'h12345678, 0); tick();
        chk("lit_6ffc_code", 32'(Raw_D_ExcCode), 32'd0);
        chk("lit_6ffc_instr", D_Instr, 32'h12345678);
        setIn(0, 0, 0, 0, 32'h2FFC, 32'hAAAA5555, 0); tick();
        chk("lit_2ffc_code", 32'(Raw_D_ExcCode), 32'd4);

        setIn(0, 0, 0, 0, 32'h3004, 32'h11111111, 0); tick();
        setIn(0, 0, 1, 0, 32'h3008, 32'h22222222, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_pc", D_PC, 32'h3004);
        end
        Stall = 0; tick();
        chk("lit_unstall_pc", D_PC, 32'h3008);

        setIn(0, 1, 1, 1, 32'h3040, 32'h33333333, 1); tick();
        chk("lit_req_pc", D_PC, 32'h4180);
        chk("lit_req_instr", D_Instr, 32'h0);
        chk("lit_req_valid", 32'(D_Valid), 32'd0);

        setIn(0, 0, 0, 1, 32'h3010, 32'h44444444, 1); tick();
        chk("lit_clr_pc", D_PC, 32'h3010);
        chk("lit_clr_instr", D_Instr, 32'h0);
        chk("lit_clr_bd", 32'(D_BD), 32'd0);
        chk("lit_clr_valid", 32'(D_Valid), 32'd0);
        setIn(0, 0, 0, 0, 32'h3020, 32'h55555555, 1); tick();
        setIn(0, 0, 1, 1, 32'h3030, 32'h66666666, 0); tick();
        chk("lit_clrstall_pc", D_PC, 32'h3020);
        chk("lit_clrstall_bd", 32'(D_BD), 32'd1);
        chk("lit_clrstall_valid", 32'(D_Valid), 32'd1);

        setIn(0, 0, 0, 0, 32'h3001, 32'h77777777, 0); tick();
        setIn(0, 0, 1, 0, 32'h3000, 32'h88888888, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lit_held_code", 32'(Raw_D_ExcCode), 32'd4);
        end
        reset = 1; tick();
        chk("lit_rst_stall_pc", D_PC, 32'h3000);
        chk("lit_rst_stall_code", 32'(Raw_D_ExcCode), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       pc = 32'h6FFC;
                1:       pc = 32'h7000;
                2:       pc = 32'h3000;
                3:       pc = 32'h2FFC;
                4:       pc = $urandom();
                5:       pc = 32'h3000 + 32'($urandom_range(0, 32'h3FFF));
                default: pc = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            endcase
            setIn($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  pc, $urandom(), 1'($urandom_range(0, 1)));
            tick();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_d_reg.md
F_D_REG -- requirements
Module: f_d_reg

Interface
REQ-001 SHALL have port clk  input  1  single clock; every state change occurs on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port Req  input  1  exception/interrupt request from CP0; flushes the D stage.
REQ-004 SHALL have port Stall  input  1  hazard stall; D stage holds its contents.
REQ-005 SHALL have port Clr  input  1  bubble request (eret in D squashes the fetched delay-slot instruction).
REQ-006 SHALL have port F_PC  input  32  fetch PC.
REQ-007 SHALL have port F_Instr  input  32  instruction word fetched at F_PC.
REQ-008 SHALL have port F_BD  input  1  fetched instruction is in a branch/jump delay slot.
REQ-009 SHALL have port D_PC  output  32  registered PC.
REQ-010 SHALL have port D_Instr  output  32  registered instruction.
REQ-011 SHALL have port Raw_D_ExcCode  output  5  registered fetch-stage exception code, consumed by the D-stage exception selector.
REQ-012 SHALL have port D_BD  output  1  registered delay-slot flag.
REQ-013 SHALL have port D_Valid  output  1  1 = real instruction, 0 = bubble.

Function
REQ-014 SHALL compute F_ExcCode combinationally: 5'd4 (AdEL) if F_PC[1:0]!=0, or F_PC<32'h0000_3000, or F_PC>32'h0000_6FFC; otherwise 5'd0.
REQ-015 SHALL substitute 32'h0 (nop) for F_Instr when F_ExcCode!=0; F_PC and F_BD are still latched unchanged.
REQ-016 SHALL update registers on each rising edge using the priority reset > Req > Stall > Clr > normal load.
REQ-017 SHALL, on Req: D_PC=32'h0000_4180, D_Instr=0, Raw_D_ExcCode=0, D_BD=0, D_Valid=0.
REQ-018 SHALL, on Stall without Req: hold all five outputs unchanged; Clr is ignored in that cycle.
REQ-019 SHALL, on Clr without Req/Stall: D_PC=F_PC, D_Instr=0, Raw_D_ExcCode=0, D_BD=0, D_Valid=0.
REQ-020 SHALL, on normal load: D_PC=F_PC, D_Instr=masked F_Instr, Raw_D_ExcCode=F_ExcCode, D_BD=F_BD, D_Valid=1.
REQ-021 SHALL have a latency of exactly one cycle from F inputs to D outputs; no combinational path from inputs to outputs.
REQ-022 SHALL keep a held exception code stable for any number of consecutive Stall cycles.
REQ-023 SHALL treat F_PC=32'h0000_6FFC as legal and F_PC=32'h0000_7000 as AdEL (inclusive upper bound).

Reset
REQ-024 SHALL, on reset high at a rising edge: D_PC=32'h0000_3000, D_Instr=0, Raw_D_ExcCode=0, D_BD=0, D_Valid=0, overriding Req, Stall and Clr.
REQ-025 SHALL, on reset asserted mid-stall, discard the held state and take the reset values on that edge.

Structure
REQ-026 SHALL take constants from a shared package: EXC_NONE=5'd0, EXC_ADEL=5'd4, PC_RESET=32'h3000, PC_HANDLER=32'h4180, IM_LO=32'h3000, IM_HI=32'h6FFC.
REQ-027 SHALL place the fetch address check (REQ-014/015) in one combinational sub-module f_exc_check, instantiated once.
REQ-028 SHALL implement the register bank as a single clocked process with no latches.

Verification
REQ-029 SHALL cover: reset=1 for 2 cycles, then F_PC=0x3000, F_Instr=0x3C010001 -> next edge D_PC=0x3000, D_Instr=0x3C010001, Raw_D_ExcCode=0, D_Valid=1.
REQ-030 SHALL cover: F_PC=0x3002, F_Instr=0x12345678 -> D_Instr=0, Raw_D_ExcCode=4, D_PC=0x3002, D_Valid=1; repeat with F_PC=0x7000 -> code 4; with F_PC=0x6FFC -> code 0.
REQ-031 SHALL cover: load F_PC=0x3004, then Stall=1 for 3 cycles while F_PC changes to 0x3008 -> D_PC stays 0x3004 throughout; Stall=0 -> D_PC=0x3008.
REQ-032 SHALL cover: Req=1 together with Stall=1 and Clr=1 -> D_PC=0x4180, D_Instr=0, D_Valid=0.
REQ-033 SHALL cover: Clr=1, F_PC=0x3010, F_BD=1 -> D_PC=0x3010, D_Instr=0, D_BD=0, D_Valid=0; Clr=1 with Stall=1 -> outputs held.
REQ-034 SHALL cover: Stall=1 holding Raw_D_ExcCode=4, then reset=1 -> D_PC=0x3000, Raw_D_ExcCode=0.
